// File: rtl/writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_pkg
// Shared constants for the integer register file write path.
//   XLEN        : register data width (also used by the register file)
//   REG_ADDR_W  : register address width (also used by the register file)
//   SRC_ALU/MUL/LSU : result source indices on the writeback arbiter
// Helper:
//   rr_next()   : round-robin successor of an index, wrapping modulo n
// -----------------------------------------------------------------------------
package writeback_arbiter_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_LSU = 2;

  // Successor of idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with the rotating priority pointer held inside.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (pointer -> 0, grant forced 0)
//   valid_i  : N request bits
//   grant_o  : one-hot grant (combinational from valid_i and the pointer)
//   idx_o    : encoded index of the granted request (don't care if !any_o)
//   any_o    : a grant is issued this cycle
//   ptr_o    : current pointer value (highest-priority index), for debug
// Handshake: a requester k transfers when valid_i[k] && grant_o[k]; the
// grant never depends on anything but valid_i and the pointer.
// -----------------------------------------------------------------------------
module rr_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         valid_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] ptr_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  // Search starts at the pointer and wraps; the first valid request wins.
  always_comb begin
    int k;
    k       = 0;
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(r_ptr) + i;
      if (k >= N) k = k - N;
      if (!w_any && valid_i[k]) begin
        w_any      = 1'b1;
        w_idx      = IDX_W'(k);
        w_grant[k] = 1'b1;
      end
    end
    // Nothing is consumed while reset is held.
    if (rst_i) begin
      w_grant = '0;
      w_any   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= IDX_W'(rr_next(int'(w_idx), N));
    end
  end

  assign grant_o = w_grant;
  assign idx_o   = w_idx;
  assign any_o   = w_any;
  assign ptr_o   = r_ptr;

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Merges results from NUM_SRC execution units (0=ALU, 1=MUL/DIV, 2=LSU) onto
// the single register file write port. One round-robin grant per cycle; the
// granted result is registered and appears on the write port one cycle later.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   src_valid_i  : per-source result valid
//   src_rd_i     : per-source destination, source k at [k*REG_ADDR_W +: REG_ADDR_W]
//   src_data_i   : per-source data, source k at [k*XLEN +: XLEN]
//   src_ready_o  : one-hot grant; the granted result is consumed this cycle
//   write_en_o   : register file write enable (0 for results targeting x0)
//   write_addr_o : register file write address
//   write_data_o : register file write data
// Optional (macro WB_PERF_EN):
//   perf_writes_o    : cycles with write_en_o=1, wraps at 2^32
//   perf_conflicts_o : cycles with more than one src_valid_i bit set, wraps
// Handshake: source k transfers when src_valid_i[k] && src_ready_o[k]; a
// source holds valid/rd/data stable until granted, and ready depends only on
// src_valid_i and the internal round-robin pointer.
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int XLEN       = writeback_arbiter_pkg::XLEN,
  parameter int REG_ADDR_W = writeback_arbiter_pkg::REG_ADDR_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd_i,
  input  logic [NUM_SRC*XLEN-1:0]       src_data_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
`ifdef WB_PERF_EN
  output logic [31:0]                   perf_writes_o,
  output logic [31:0]                   perf_conflicts_o,
`endif
  output logic                          write_en_o,
  output logic [REG_ADDR_W-1:0]         write_addr_o,
  output logic [XLEN-1:0]               write_data_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]    w_grant;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic [IDX_W-1:0]      w_ptr;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;

  logic                  r_write_en;
  logic [REG_ADDR_W-1:0] r_write_addr;
  logic [XLEN-1:0]       r_write_data;

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (src_valid_i),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any),
    .ptr_o   (w_ptr)
  );

  // Pointer is kept for debug visibility only; nothing in the datapath uses it.
  logic w_unused;
  assign w_unused = ^w_ptr;

  assign w_sel_rd   = src_rd_i[int'(w_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign w_sel_data = src_data_i[int'(w_idx)*XLEN +: XLEN];

  // Output stage never stalls: the register file accepts every write.
  // x0 results still load addr/data but never raise the enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else if (w_any) begin
      r_write_en   <= (w_sel_rd != '0);
      r_write_addr <= w_sel_rd;
      r_write_data <= w_sel_data;
    end else begin
      r_write_en   <= 1'b0;
    end
  end

  assign src_ready_o  = w_grant;
  assign write_en_o   = r_write_en;
  assign write_addr_o = r_write_addr;
  assign write_data_o = r_write_data;

`ifdef WB_PERF_EN
  logic [31:0] r_perf_writes;
  logic [31:0] r_perf_conflicts;
  logic        w_conflict;

  assign w_conflict = ($countones(src_valid_i) > 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_writes    <= '0;
      r_perf_conflicts <= '0;
    end else begin
      if (r_write_en) r_perf_writes    <= r_perf_writes + 32'd1;
      if (w_conflict) r_perf_conflicts <= r_perf_conflicts + 32'd1;
    end
  end

  assign perf_writes_o    = r_perf_writes;
  assign perf_conflicts_o = r_perf_conflicts;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int N  = 3;
  localparam int AW = writeback_arbiter_pkg::REG_ADDR_W;
  localparam int DW = writeback_arbiter_pkg::XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- source stimulus ----------------
  logic [N-1:0]      v = '0;
  logic [AW-1:0]     rd  [N];
  logic [DW-1:0]     dat [N];
  logic [N*AW-1:0]   src_rd_flat;
  logic [N*DW-1:0]   src_data_flat;

  always_comb begin
    src_rd_flat   = '0;
    src_data_flat = '0;
    for (int k = 0; k < N; k++) begin
      src_rd_flat[k*AW +: AW]   = rd[k];
      src_data_flat[k*DW +: DW] = dat[k];
    end
  end

  logic [N-1:0]  src_ready_o;
  logic          write_en_o;
  logic [AW-1:0] write_addr_o;
  logic [DW-1:0] write_data_o;
`ifdef WB_PERF_EN
  logic [31:0]   perf_writes_o;
  logic [31:0]   perf_conflicts_o;
`endif

  writeback_arbiter #(
    .NUM_SRC    (N),
    .XLEN       (DW),
    .REG_ADDR_W (AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .src_valid_i      (v),
    .src_rd_i         (src_rd_flat),
    .src_data_i       (src_data_flat),
    .src_ready_o      (src_ready_o),
`ifdef WB_PERF_EN
    .perf_writes_o    (perf_writes_o),
    .perf_conflicts_o (perf_conflicts_o),
`endif
    .write_en_o       (write_en_o),
    .write_addr_o     (write_addr_o),
    .write_data_o     (write_data_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_err    = 0;

  int            m_ptr = 0;
  logic          m_en  = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  longint        m_writes = 0;
  longint        m_conf   = 0;
  int            wait_cnt [N];
  // Expected write-port contents, pushed at grant and popped one cycle later.
  logic [AW+DW:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner by the round-robin rule: first valid at ptr, ptr+1, ... mod N.
  function automatic int model_grant(input int ptr, input logic [N-1:0] vv);
    for (int i = 0; i < N; i++)
      if (vv[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // One clock cycle: check at the falling edge, advance the model at the
  // rising edge, return 1 time unit after it with the granted index.
  task automatic tick(output int g);
    int            ga;
    logic [N-1:0]  exp_ready;
    logic [AW+DW:0] e;
    @(negedge clk);
    ga = rst ? -1 : model_grant(m_ptr, v);
    exp_ready = (ga >= 0) ? N'(1 << ga) : '0;
    chk("ready", 64'(src_ready_o), 64'(exp_ready));
    chk("write_en", 64'(write_en_o), 64'(m_en));
    chk("write_addr", 64'(write_addr_o), 64'(m_addr));
    chk("write_data", write_data_o, m_data);
`ifdef WB_PERF_EN
    chk("perf_writes", 64'(perf_writes_o), 64'(m_writes[31:0]));
    chk("perf_conflicts", 64'(perf_conflicts_o), 64'(m_conf[31:0]));
`endif
    @(posedge clk);
    if (rst) begin
      m_writes = 0;
      m_conf   = 0;
    end else begin
      m_writes = m_writes + (m_en ? 1 : 0);
      m_conf   = m_conf + (($countones(v) > 1) ? 1 : 0);
    end
    for (int k = 0; k < N; k++) begin
      if (ga == k) begin
        chk("starvation", 64'(wait_cnt[k] < N), 64'd1);
        wait_cnt[k] = 0;
      end else if (!rst && v[k]) begin
        wait_cnt[k]++;
      end else begin
        wait_cnt[k] = 0;
      end
    end
    if (rst) begin
      m_ptr  = 0;
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
      exp_q.delete();
    end else if (ga >= 0) begin
      exp_q.push_back({(rd[ga] != 0), rd[ga], dat[ga]});
      e      = exp_q.pop_front();
      m_en   = e[AW+DW];
      m_addr = e[AW+DW-1:DW];
      m_data = e[DW-1:0];
      m_ptr  = (ga + 1) % N;
    end else begin
      m_en = 1'b0;
    end
    #1;
    g = ga;
  endtask

  task automatic do_reset(input int cycles);
    int g;
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) tick(g);
    rst = 1'b0;
  endtask

  // Bounded run time regardless of what the DUT does.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int g;
    for (int k = 0; k < N; k++) begin
      rd[k] = '0; dat[k] = '0; wait_cnt[k] = 0;
    end
    #1;

    // Reset, then a single source.
    do_reset(2);
    chk("rst_write_en", 64'(write_en_o), 64'd0);
    chk("rst_write_addr", 64'(write_addr_o), 64'd0);
    chk("rst_write_data", write_data_o, 64'd0);
    v = 3'b001; rd[0] = 5; dat[0] = 64'hDEAD_BEEF;
    #1 chk("single_ready", 64'(src_ready_o), 64'b001);
    tick(g);
    v = '0;
    #1;
    chk("single_wen", 64'(write_en_o), 64'd1);
    chk("single_addr", 64'(write_addr_o), 64'd5);
    chk("single_data", write_data_o, 64'hDEAD_BEEF);
    tick(g);

    // Round-robin with all sources continuously valid.
    do_reset(1);
    v = 3'b111; rd[0] = 1; rd[1] = 2; rd[2] = 3;
    dat[0] = 64'h100; dat[1] = 64'h200; dat[2] = 64'h300;
    #1 chk("rr_grant0", 64'(src_ready_o), 64'b001);
    tick(g);
    #1 chk("rr_grant1", 64'(src_ready_o), 64'b010);
    chk("rr_addr0", 64'(write_addr_o), 64'd1);
    tick(g);
    #1 chk("rr_grant2", 64'(src_ready_o), 64'b100);
    chk("rr_addr1", 64'(write_addr_o), 64'd2);
    tick(g);
    #1 chk("rr_grant3", 64'(src_ready_o), 64'b001);
    chk("rr_addr2", 64'(write_addr_o), 64'd3);
    tick(g);
    v = '0;
    #1 chk("rr_addr3", 64'(write_addr_o), 64'd1);
    tick(g);

    // x0 discard.
    do_reset(1);
    v = 3'b100; rd[2] = 0; dat[2] = 64'h1234;
    #1 chk("x0_ready", 64'(src_ready_o), 64'b100);
    tick(g);
    v = '0;
    #1;
    chk("x0_wen", 64'(write_en_o), 64'd0);
    chk("x0_addr", 64'(write_addr_o), 64'd0);
    chk("x0_data", write_data_o, 64'h1234);
    tick(g);

    // Pointer holds across idle cycles.
    do_reset(1);
    v = 3'b010; rd[1] = 4; dat[1] = 64'h44;
    #1 chk("hold_grant_src1", 64'(src_ready_o), 64'b010);
    tick(g);
    v = '0;
    for (int i = 0; i < 3; i++) tick(g);
    v = 3'b011; rd[0] = 6; dat[0] = 64'h66; rd[1] = 8; dat[1] = 64'h88;
    #1 chk("hold_first_src0", 64'(src_ready_o), 64'b001);
    tick(g);
    v[0] = 1'b0;
    #1 chk("hold_then_src1", 64'(src_ready_o), 64'b010);
    tick(g);
    v = '0;
    tick(g);

    // Reset mid-stream.
    do_reset(1);
    v = 3'b101; rd[0] = 7; dat[0] = 64'h77; rd[2] = 9; dat[2] = 64'h99;
    #1 chk("mid_grant_src0", 64'(src_ready_o), 64'b001);
    tick(g);
    rst = 1'b1;
    #1 chk("mid_rst_ready", 64'(src_ready_o), 64'b000);
    chk("mid_prior_write", 64'(write_en_o), 64'd1);
    tick(g);
    rst = 1'b0;
    #1;
    chk("mid_post_wen", 64'(write_en_o), 64'd0);
    chk("mid_post_addr", 64'(write_addr_o), 64'd0);
    chk("mid_post_src0_first", 64'(src_ready_o), 64'b001);
    tick(g);
    v = '0;
    tick(g);

`ifdef WB_PERF_EN
    // Performance counters: 10 cycles of full contention.
    do_reset(1);
    v = 3'b111; rd[0] = 1; rd[1] = 2; rd[2] = 3;
    for (int i = 0; i < 10; i++) tick(g);
    v = '0;
    tick(g);
    chk("perf_conflicts_10", 64'(perf_conflicts_o), 64'd10);
    chk("perf_writes_10", 64'(perf_writes_o), 64'd10);
`endif

    // Randomized traffic with occasional resets.
    do_reset(1);
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < N; k++) begin
        if (!v[k] && $urandom_range(0, 2) == 0) begin
          v[k]   = 1'b1;
          rd[k]  = AW'($urandom_range(0, 31));
          dat[k] = {$urandom, $urandom};
        end
      end
      tick(g);
      if (g >= 0) begin
        v[g] = 1'($urandom_range(0, 1));
        rd[g]  = AW'($urandom_range(0, 31));
        dat[g] = {$urandom, $urandom};
      end
    end
    rst = 1'b0;
    v = '0;
    tick(g);
    tick(g);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writer side of the integer register file: merges results from several execution units onto the single register file write port (write_en / write_addr / write_data).
- Per-source valid/ready handshake; round-robin arbitration, one write per cycle; registered output stage.
- Sits between the execute/memory units (ALU, MUL/DIV, LSU) and the register file.

Parameters:
- NUM_SRC, 3, number of result sources (index 0 = ALU, 1 = MUL/DIV, 2 = LSU); legal range 2..8
- XLEN, 64, data width
- REG_ADDR_W, 5, register address width

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, synchronous, active-high
- src_valid_i  input  NUM_SRC  per-source result valid
- src_rd_i  input  NUM_SRC*REG_ADDR_W  per-source destination register; source k at bits [k*REG_ADDR_W +: REG_ADDR_W]
- src_data_i  input  NUM_SRC*XLEN  per-source result data; source k at bits [k*XLEN +: XLEN]
- src_ready_o  output  NUM_SRC  one-hot grant; the result is consumed this cycle
- write_en_o  output  1  register file write enable
- write_addr_o  output  REG_ADDR_W  register file write address
- write_data_o  output  XLEN  register file write data

Behaviour:
- Clock and reset:
  - One clock (clk_i). Reset is synchronous and active-high (rst_i).
  - Reset values: write_en_o=0, write_addr_o=0, write_data_o=0, round-robin pointer rr_ptr=0.
  - src_ready_o is forced to 0 in any cycle where rst_i=1.
- Handshake:
  - Transfer occurs when src_valid_i[k] && src_ready_o[k].
  - A source holds valid, rd and data stable until it is granted. Behaviour on a violation is undefined and not checked.
  - src_ready_o is combinational from src_valid_i and rr_ptr. It never depends on src_rd_i or src_data_i.
- Arbitration:
  - Grant goes to the first k with src_valid_i[k]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_SRC.
  - At most one grant per cycle.
  - On a grant to k: rr_ptr <= (k+1) mod NUM_SRC. With no grant, rr_ptr holds.
- Output stage, latency 1 cycle from grant to write_en_o:
  - On a grant to k, at the next edge: write_addr_o <= rd_k, write_data_o <= data_k, write_en_o <= (rd_k != 0).
  - A result targeting x0 is accepted (ready=1) and discarded. write_en_o=0 that cycle, but addr/data still load.
  - With no grant: write_en_o <= 0, and write_addr_o / write_data_o hold their last values.
- The register file never backpressures, so the output stage never stalls. Throughput is 1 write per cycle.
- Starvation bound: a continuously valid source is granted within NUM_SRC cycles.
- Reset during operation:
  - Any pending, ungranted source result is not consumed. Sources re-present it after reset.
  - A write registered in the cycle before reset still appears on the output for one cycle.
  - Outputs return to their reset values at the reset edge.

Optional Feature:
- Macro WB_PERF_EN adds two outputs:
  - perf_writes_o (32-bit): count of cycles with write_en_o=1.
  - perf_conflicts_o (32-bit): count of cycles where more than one src_valid_i bit is set.
- Both counters reset to 0 and wrap at 2^32.
- Without the macro, neither the ports nor the counters exist. Arbitration and write behaviour are identical in both builds.

Decomposition:
- Shared package holds:
  - XLEN and REG_ADDR_W constants (also used by the register file).
  - Source index constants SRC_ALU=0, SRC_MUL=1, SRC_LSU=2.
- One sub-module, rr_arbiter: NUM_SRC-wide valid vector plus pointer in, one-hot grant and encoded index out; pointer register inside. Slicing and the output stage stay in the top level.

Test Plan:
- Reset, then a single source: assert rst_i 2 cycles; check all outputs 0. Then src0 valid, rd=5, data=64'hDEAD_BEEF -> src_ready_o=3'b001 the same cycle; next cycle write_en_o=1, write_addr_o=5, write_data_o=64'hDEAD_BEEF.
- Round-robin: all three sources valid continuously with rd=1,2,3 -> grants 001,010,100,001 on consecutive cycles; write_addr_o sequence 1,2,3,1 one cycle later.
- x0 discard: src2 valid, rd=0, data=64'h1234 -> src_ready_o[2]=1; next cycle write_en_o=0 and write_addr_o=0.
- Pointer hold: grant src1 (rr_ptr becomes 2), then 3 idle cycles, then src0 and src1 valid together -> src0 is granted first (search starts at 2, wraps to 0); then src1.
- Reset mid-stream: src0 and src2 valid, assert rst_i on the cycle src2 would win -> src_ready_o=0 that cycle; next cycle write_en_o=0 and rr_ptr=0; after reset releases, src0 is granted first.
- WB_PERF_EN build: 10 cycles with all three sources valid -> perf_conflicts_o=10 and perf_writes_o=10, read once the last write has registered.
